// File: rtl/sseg_pkg.sv
// Shared constants and types for the 7-segment scanner.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package sseg_pkg;

    localparam int NUM_DIGITS = 3;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } scanState_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b0000011;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_D   = 7'b0100001;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_F   = 7'b0001110;

endpackage

// File: rtl/sseg_decoder.sv
// BCD/hex code to active-low 7-segment pattern.
// Optional macro SSEG_BLANK_INVALID_EN: when defined, codes 10-15 show a dark
// digit; otherwise they show hex glyphs A b C d E F for debugging.
module sseg_decoder
    import sseg_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    // Pure lookup; codes 0-9 are the same in both builds
    always_comb begin
        seg_o = SEG_OFF;
        case (code_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
`ifdef SSEG_BLANK_INVALID_EN
            default: seg_o = SEG_OFF;
`else
            4'd10:   seg_o = SEG_A;
            4'd11:   seg_o = SEG_B;
            4'd12:   seg_o = SEG_C;
            4'd13:   seg_o = SEG_D;
            4'd14:   seg_o = SEG_E;
            default: seg_o = SEG_F;
`endif
        endcase
    end

endmodule

// File: rtl/sseg_scanner.sv
// Three-digit multiplexed 7-segment driver for the voltage readout.
// Paces the calculator with a periodic one-cycle flag, snapshots its digits
// one cycle later, and scans them with a blank gap at the start of each slot.
// Optional macro SSEG_BLANK_INVALID_EN (see sseg_decoder).
module sseg_scanner
    import sseg_pkg::*;
#(
    parameter int UPDATE_CYC = 6_000_000,
    parameter int DIGIT_CYC  = 12_000,
    parameter int BLANK_CYC  = 120
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] integer_data,
    input  logic [3:0] float1_data,
    input  logic [3:0] float2_data,
    output logic       flag,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] an
);

    localparam int UPD_W  = (UPDATE_CYC > 1) ? $clog2(UPDATE_CYC) : 1;
    localparam int SCAN_W = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;

    localparam logic [UPD_W-1:0]  UPD_LAST   = UPD_W'(UPDATE_CYC - 1);
    localparam logic [SCAN_W-1:0] BLANK_LAST = SCAN_W'(BLANK_CYC - 1);
    localparam logic [SCAN_W-1:0] ON_LAST    = SCAN_W'(DIGIT_CYC - BLANK_CYC - 1);
    localparam logic [1:0]        DIG_LAST   = 2'(NUM_DIGITS - 1);

    logic [UPD_W-1:0]  updCnt_q, updCnt_d;
    logic              flag_q, flag_d;
    logic              flagDly_q;
    logic [3:0]        snap_q [NUM_DIGITS];

    scanState_e        state_q, state_d;
    logic [SCAN_W-1:0] scanCnt_q, scanCnt_d;
    logic [1:0]        dig_q, dig_d;

    logic [3:0]        decodeCode;
    logic [6:0]        decodeSeg;
    logic [2:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    // Free-running update counter; flag is registered so it is high while the count sits at its last value
    always_comb begin
        updCnt_d = (updCnt_q == UPD_LAST) ? '0 : updCnt_q + UPD_W'(1);
        flag_d   = (updCnt_d == UPD_LAST);
    end

    // Update counter, flag and its one-cycle-delayed copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            updCnt_q  <= '0;
            flag_q    <= 1'b0;
            flagDly_q <= 1'b0;
        end else begin
            updCnt_q  <= updCnt_d;
            flag_q    <= flag_d;
            flagDly_q <= flag_q;
        end
    end

    // Capture all three digits together the cycle the calculator outputs become valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap_q[i] <= '0;
            end
        end else if (flagDly_q) begin
            snap_q[0] <= integer_data;
            snap_q[1] <= float1_data;
            snap_q[2] <= float2_data;
        end
    end

    // Scan sequencing: blank phase then lit phase per digit, advancing the digit after each lit phase
    always_comb begin
        state_d   = state_q;
        scanCnt_d = scanCnt_q + SCAN_W'(1);
        dig_d     = dig_q;
        case (state_q)
            S_BLANK: begin
                if (scanCnt_q == BLANK_LAST) begin
                    state_d   = S_ON;
                    scanCnt_d = '0;
                end
            end
            default: begin
                if (scanCnt_q == ON_LAST) begin
                    state_d   = S_BLANK;
                    scanCnt_d = '0;
                    dig_d     = (dig_q == DIG_LAST) ? 2'd0 : dig_q + 2'd1;
                end
            end
        endcase
    end

    // Select the snapshot digit that will be lit in the coming cycle
    always_comb begin
        decodeCode = snap_q[2];
        case (dig_d)
            2'd0:    decodeCode = snap_q[0];
            2'd1:    decodeCode = snap_q[1];
            default: decodeCode = snap_q[2];
        endcase
    end

    sseg_decoder u_decoder (
        .code_i (decodeCode),
        .seg_o  (decodeSeg)
    );

    // Output values computed from the next state so the registered outputs line up with the FSM
    always_comb begin
        an_d  = 3'b111;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_d == S_ON) begin
            an_d  = ~(3'b001 << dig_d);
            seg_d = decodeSeg;
            dp_d  = (dig_d != 2'd0);
        end
    end

    // Scan FSM state register and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_BLANK;
            scanCnt_q <= '0;
            dig_q     <= 2'd0;
            an_q      <= 3'b111;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            scanCnt_q <= scanCnt_d;
            dig_q     <= dig_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign flag = flag_q;
    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;

endmodule

// File: tb/tb_sseg_scanner.sv
// Directed bench for sseg_scanner with short timing parameters
// (UPDATE_CYC=50, DIGIT_CYC=10, BLANK_CYC=2). Honours SSEG_BLANK_INVALID_EN.
module tb_sseg_scanner;

    logic       clk;
    logic       rst_n;
    logic [3:0] integer_data;
    logic [3:0] float1_data;
    logic [3:0] float2_data;
    logic       flag;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] an;

    int compared;
    int mismatched;

    sseg_scanner #(
        .UPDATE_CYC (50),
        .DIGIT_CYC  (10),
        .BLANK_CYC  (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .integer_data (integer_data),
        .float1_data  (float1_data),
        .float2_data  (float2_data),
        .flag         (flag),
        .seg          (seg),
        .dp           (dp),
        .an           (an)
    );

    // 100 MHz-style bench clock; only cycle counts matter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the negedge of the next cycle in which flag is high
    task automatic waitForFlag(output bit found);
        found = 1'b0;
        for (int k = 0; k < 120 && !found; k++) begin
            @(negedge clk);
            if (flag === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        int  edges;
        int  gap;
        bit  found;
        rst_n        = 1'b0;
        integer_data = 4'd4;
        float1_data  = 4'd7;
        float2_data  = 4'd3;
        repeat (3) @(negedge clk);
        compared++;
        if (an !== 3'b111) begin mismatched++; $display("[TB] FAIL reset_an got=%b expected=111", an); end
        compared++;
        if (seg !== 7'h7F) begin mismatched++; $display("[TB] FAIL reset_seg got=%b expected=1111111", seg); end
        compared++;
        if (dp !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_dp got=%b expected=1", dp); end
        compared++;
        if (flag !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_flag got=%b expected=0", flag); end

        rst_n = 1'b1;
        edges = 0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            edges++;
            if (flag === 1'b1) found = 1'b1;
        end
        compared++;
        if (!found || edges != 49) begin
            mismatched++;
            $display("[TB] FAIL first_flag edges=%0d found=%0d expected edges=49", edges, found);
        end

        @(negedge clk);
        gap = 1;
        compared++;
        if (flag !== 1'b0) begin mismatched++; $display("[TB] FAIL flag_width got=%b expected=0", flag); end

        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            gap++;
            if (flag === 1'b1) found = 1'b1;
        end
        compared++;
        if (!found || gap != 50) begin
            mismatched++;
            $display("[TB] FAIL flag_period gap=%0d found=%0d expected gap=50", gap, found);
        end
    endtask

    task automatic test_snapshot();
        bit         found;
        int         litCnt [3];
        int         blankCnt;
        logic [2:0] prevLit;
        logic [2:0] nextLit;
        waitForFlag(found);
        compared++;
        if (!found) begin mismatched++; $display("[TB] FAIL snap_flag_timeout found=0 expected=1"); end
        integer_data = 4'd1; float1_data = 4'd1; float2_data = 4'd1;
        @(negedge clk);
        integer_data = 4'd4; float1_data = 4'd7; float2_data = 4'd3;
        @(negedge clk);
        integer_data = 4'd1; float1_data = 4'd1; float2_data = 4'd1;
        @(negedge clk);

        for (int d = 0; d < 3; d++) litCnt[d] = 0;
        blankCnt = 0;
        prevLit  = 3'b111;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (an != 3'b111 && prevLit != 3'b111 && an != prevLit) begin
                nextLit = (prevLit == 3'b110) ? 3'b101 : (prevLit == 3'b101) ? 3'b011 : 3'b110;
                compared++;
                if (an !== nextLit) begin mismatched++; $display("[TB] FAIL snap_order got=%b expected=%b", an, nextLit); end
            end
            case (an)
                3'b110: begin
                    litCnt[0]++;
                    compared++;
                    if (seg !== 7'b0011001 || dp !== 1'b0) begin mismatched++; $display("[TB] FAIL snap_dig0 seg=%b dp=%b expected seg=0011001 dp=0", seg, dp); end
                    prevLit = an;
                end
                3'b101: begin
                    litCnt[1]++;
                    compared++;
                    if (seg !== 7'b1111000 || dp !== 1'b1) begin mismatched++; $display("[TB] FAIL snap_dig1 seg=%b dp=%b expected seg=1111000 dp=1", seg, dp); end
                    prevLit = an;
                end
                3'b011: begin
                    litCnt[2]++;
                    compared++;
                    if (seg !== 7'b0110000 || dp !== 1'b1) begin mismatched++; $display("[TB] FAIL snap_dig2 seg=%b dp=%b expected seg=0110000 dp=1", seg, dp); end
                    prevLit = an;
                end
                3'b111: begin
                    blankCnt++;
                    compared++;
                    if (seg !== 7'h7F || dp !== 1'b1) begin mismatched++; $display("[TB] FAIL snap_blank seg=%b dp=%b expected seg=1111111 dp=1", seg, dp); end
                end
                default: begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL snap_anode got=%b expected one-hot-low or 111", an);
                end
            endcase
        end
        for (int d = 0; d < 3; d++) begin
            compared++;
            if (litCnt[d] != 8) begin mismatched++; $display("[TB] FAIL snap_lit_count dig=%0d got=%0d expected=8", d, litCnt[d]); end
        end
        compared++;
        if (blankCnt != 6) begin mismatched++; $display("[TB] FAIL snap_blank_count got=%0d expected=6", blankCnt); end
    endtask

    task automatic test_blanking();
        logic [2:0] curAn;
        int         runLen;
        bit         firstRun;
        int         expLen;
        @(negedge clk);
        curAn    = an;
        runLen   = 1;
        firstRun = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            compared++;
            if ($countones(~an) > 1) begin mismatched++; $display("[TB] FAIL blank_overlap an=%b expected at most one low", an); end
            if (an == curAn) begin
                runLen++;
            end else begin
                if (!firstRun) begin
                    expLen = (curAn == 3'b111) ? 2 : 8;
                    compared++;
                    if (runLen != expLen) begin mismatched++; $display("[TB] FAIL blank_run an=%b got=%0d expected=%0d", curAn, runLen, expLen); end
                end
                firstRun = 1'b0;
                curAn    = an;
                runLen   = 1;
            end
        end
    endtask

    task automatic test_over_range();
        bit         found;
        logic [6:0] expSeg [3];
        int         idx;
        expSeg[0] = 7'b0010010;
        expSeg[1] = 7'b1000000;
        expSeg[2] = 7'b1000000;
        integer_data = 4'd5; float1_data = 4'd0; float2_data = 4'd0;
        waitForFlag(found);
        compared++;
        if (!found) begin mismatched++; $display("[TB] FAIL range_flag_timeout found=0 expected=1"); end
        repeat (3) @(negedge clk);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            idx = (an == 3'b110) ? 0 : (an == 3'b101) ? 1 : (an == 3'b011) ? 2 : -1;
            if (idx >= 0) begin
                compared++;
                if (seg !== expSeg[idx]) begin mismatched++; $display("[TB] FAIL range_dig%0d got=%b expected=%b", idx, seg, expSeg[idx]); end
            end
        end
    endtask

    task automatic test_invalid_code();
        bit         found;
        logic [6:0] expSeg [3];
        int         idx;
        expSeg[0] = 7'b0100100;
`ifdef SSEG_BLANK_INVALID_EN
        expSeg[1] = 7'h7F;
`else
        expSeg[1] = 7'b1000110;
`endif
        expSeg[2] = 7'b0010000;
        integer_data = 4'd2; float1_data = 4'hC; float2_data = 4'd9;
        waitForFlag(found);
        compared++;
        if (!found) begin mismatched++; $display("[TB] FAIL invalid_flag_timeout found=0 expected=1"); end
        repeat (3) @(negedge clk);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            idx = (an == 3'b110) ? 0 : (an == 3'b101) ? 1 : (an == 3'b011) ? 2 : -1;
            if (idx >= 0) begin
                compared++;
                if (seg !== expSeg[idx]) begin mismatched++; $display("[TB] FAIL invalid_dig%0d got=%b expected=%b", idx, seg, expSeg[idx]); end
            end
        end
    endtask

    task automatic test_mid_reset();
        bit         found;
        int         slot;
        int         pos;
        logic [2:0] expAn;
        logic [6:0] expSeg;
        logic       expDp;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (an === 3'b011) found = 1'b1;
        end
        compared++;
        if (!found) begin mismatched++; $display("[TB] FAIL midrst_dig2_timeout found=0 expected=1"); end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (an !== 3'b111) begin mismatched++; $display("[TB] FAIL midrst_an got=%b expected=111", an); end
        compared++;
        if (seg !== 7'h7F) begin mismatched++; $display("[TB] FAIL midrst_seg got=%b expected=1111111", seg); end
        compared++;
        if (dp !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_dp got=%b expected=1", dp); end
        compared++;
        if (flag !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_flag got=%b expected=0", flag); end

        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            #1;
            slot   = c / 10;
            pos    = c % 10;
            expAn  = (pos < 2) ? 3'b111 : ~(3'b001 << slot);
            expSeg = (pos < 2) ? 7'h7F : 7'b1000000;
            expDp  = (pos >= 2 && slot == 0) ? 1'b0 : 1'b1;
            compared++;
            if (an !== expAn || seg !== expSeg || dp !== expDp || flag !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL midrst_scan c=%0d an=%b seg=%b dp=%b flag=%b expected an=%b seg=%b dp=%b flag=0",
                         c, an, seg, dp, flag, expAn, expSeg, expDp);
            end
            @(negedge clk);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        compared     = 0;
        mismatched   = 0;
        rst_n        = 1'b0;
        integer_data = 4'd0;
        float1_data  = 4'd0;
        float2_data  = 4'd0;
        test_reset();
        test_snapshot();
        test_blanking();
        test_over_range();
        test_invalid_code();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
